// File: rtl/rv4028_bus_cycle_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv4028_bus_pkg
// Description : Shared types and constants for the RV4028 bus-cycle sequencer.
//               Holds the cycle FSM state encoding, the 2-bit DDR strobe
//               codes and the bit positions inside a DDR pair.
//               A DDR pair carries [0] = level in the clk-high half and
//               [1] = level in the clk-low half of the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
package rv4028_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_T1    = 3'd1,
    ST_TW    = 3'd2,
    ST_T2    = 3'd3,
    ST_ABORT = 3'd4
  } state_e;

  // Strobes are active low; the two bits are the two halves of one clock.
  localparam logic [1:0] STB_IDLE    = 2'b11;  // inactive for the whole cycle
  localparam logic [1:0] STB_LATE    = 2'b01;  // falls at the mid-cycle edge
  localparam logic [1:0] STB_ON      = 2'b00;  // asserted for the whole cycle
  localparam logic [1:0] STB_RELEASE = 2'b10;  // rises at the mid-cycle edge

  localparam int DDR_HI_IDX = 0;  // clk-high half
  localparam int DDR_LO_IDX = 1;  // clk-low half

  // Strobe code belonging to each bus-cycle phase.
  function automatic logic [1:0] stb_code(input state_e st);
    case (st)
      ST_T1:   stb_code = STB_LATE;
      ST_TW:   stb_code = STB_ON;
      ST_T2:   stb_code = STB_RELEASE;
      default: stb_code = STB_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv4028_ddr_out.sv
`default_nettype none
// ============================================================================
// Module      : rv4028_ddr_out
// Description : Generic DDR output cell for builds without ICE40 DDR I/O
//               cells. Both halves of a pair are captured on the rising
//               edge; the low-half bit is re-timed on the falling edge so
//               the pin can only change while its own half is being shown.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset (pins idle high)
//               hi_i     - level for the clk-high half (pair bit 0)
//               lo_i     - level for the clk-low half  (pair bit 1)
//               q_o      - serialised pin level
// Revision    : 1.0 - initial release
// ============================================================================
module rv4028_ddr_out #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_stage_q;
  logic [WIDTH-1:0] lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q       <= '1;
      lo_stage_q <= '1;
    end else begin
      hi_q       <= hi_i;
      lo_stage_q <= lo_i;
    end
  end

  // Second half of the same pair moves onto the pin at the falling edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= '1;
    end else begin
      lo_q <= lo_stage_q;
    end
  end

  assign q_o = clk ? hi_q : lo_q;

endmodule
`default_nettype wire

// File: rtl/rv4028_bus_cycle_gen.sv
`default_nettype none
// ============================================================================
// Module      : rv4028_bus_cycle_gen
// Description : Converts one accepted core request into a T1/Tw/T2 cycle on
//               the external 16-bit bus, with a minimum wait count, wait_n
//               stretching and an optional timeout abort. mreq/iorq/wr are
//               produced as DDR pairs so their edges can fall mid-cycle.
// Ports       : clk, rst_n               - clock, async active-low reset
//               req_*_i / req_ready_o    - request handshake from the core
//               resp_*_o                 - one-cycle completion pulse
//               addr_o, msk_n_o          - latched address / byte enables
//               mreq/iorq/wr_ddr_o       - strobe DDR pairs
//               rd_n_o                   - read strobe
//               wait_n_i                 - bus wait input
//               data_in_i, data_out_o,
//               data_oe_o                - bus data path
// Revision    : 1.0 - initial release
// ============================================================================
module rv4028_bus_cycle_gen
  import rv4028_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 16,
  parameter int MSK_W    = 2,
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic              req_io_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [MSK_W-1:0]  req_msk_n_i,
  output logic              resp_valid_o,
  output logic              resp_err_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [1:0]        mreq_ddr_o,
  output logic [1:0]        iorq_ddr_o,
  output logic [1:0]        wr_ddr_o,
  output logic              rd_n_o,
  output logic [MSK_W-1:0]  msk_n_o,
  input  logic              wait_n_i,
  input  logic [DATA_W-1:0] data_in_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              data_oe_o
);

  localparam int TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e              state_q;
  logic                write_q;
  logic                io_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MSK_W-1:0]    msk_n_q;
  logic [3:0]          wcnt_q;
  logic [TCNT_W-1:0]   tcnt_q;
  logic [TCNT_W-1:0]   tcnt_d;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [DATA_W-1:0]   resp_rdata_q;

  logic                accept;
  logic                in_cycle;
  logic [1:0]          stb;

  assign req_ready_o = (state_q == ST_IDLE) || (state_q == ST_T2);
  assign accept      = req_valid_i && req_ready_o;
  assign tcnt_d      = tcnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      io_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      msk_n_q      <= '1;
      wcnt_q       <= '0;
      tcnt_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;

      // Accept only happens in IDLE or T2, where the counters are free.
      if (accept) begin
        write_q <= req_write_i;
        io_q    <= req_io_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        msk_n_q <= req_msk_n_i;
        wcnt_q  <= 4'(MIN_WAIT);
        tcnt_q  <= '0;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) state_q <= ST_T1;
        end
        ST_T1: begin
          if (wcnt_q == 4'd0 && wait_n_i) begin
            state_q <= ST_T2;
          end else begin
            // T1 already consumes the first minimum wait count, so exactly
            // MIN_WAIT Tw cycles follow before wait_n is looked at.
            state_q <= ST_TW;
            if (wcnt_q != 4'd0) wcnt_q <= wcnt_q - 4'd1;
          end
        end
        ST_TW: begin
          if (wcnt_q != 4'd0) begin
            wcnt_q <= wcnt_q - 4'd1;
          end else if (!wait_n_i) begin
            tcnt_q <= tcnt_d;
            if (TIMEOUT != 0 && tcnt_d == TCNT_W'(TIMEOUT)) state_q <= ST_ABORT;
          end else begin
            state_q <= ST_T2;
          end
        end
        ST_T2: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= write_q ? '0 : data_in_i;
          state_q      <= accept ? ST_T1 : ST_IDLE;
        end
        ST_ABORT: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_rdata_q <= '0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes are decoded straight from state so an async reset idles the
  // pins without waiting for a clock edge.
  assign in_cycle   = (state_q == ST_T1) || (state_q == ST_TW) || (state_q == ST_T2);
  assign stb        = stb_code(state_q);
  assign mreq_ddr_o = io_q    ? STB_IDLE : stb;
  assign iorq_ddr_o = io_q    ? stb      : STB_IDLE;
  assign wr_ddr_o   = write_q ? stb      : STB_IDLE;
  assign rd_n_o     = !(in_cycle && !write_q);
  assign data_oe_o  = in_cycle && write_q;

  assign addr_o       = addr_q;
  assign msk_n_o      = msk_n_q;
  assign data_out_o   = wdata_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rv4028_bus_cycle_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv4028_bus_cycle_gen
// Description : Scoreboard bench for rv4028_bus_cycle_gen. Instance 0 uses
//               TIMEOUT=255, instance 1 uses TIMEOUT=4. Stimulus pushes the
//               expected per-cycle bus state and responses; one monitor pops
//               and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv4028_bus_cycle_gen;

  typedef struct {
    int          cyc;
    logic [1:0]  mreq;
    logic [1:0]  iorq;
    logic [1:0]  wr;
    logic        rdn;
    logic        oe;
    logic [31:0] addr;
    logic [1:0]  msk;
    logic [15:0] dout;
  } bus_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [15:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic        req_io    [2];
  logic [31:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic [1:0]  req_msk_n [2];
  logic        resp_valid[2];
  logic        resp_err  [2];
  logic [15:0] resp_rdata[2];
  logic [31:0] addr      [2];
  logic [1:0]  mreq      [2];
  logic [1:0]  iorq      [2];
  logic [1:0]  wr        [2];
  logic        rd_n      [2];
  logic [1:0]  msk_n     [2];
  logic        wait_n    [2];
  logic [15:0] data_in   [2];
  logic [15:0] data_out  [2];
  logic        data_oe   [2];

  bus_t busq[2][$];
  rsp_t rspq[2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv4028_bus_cycle_gen #(.ADDR_W(32), .DATA_W(16), .MSK_W(2), .MIN_WAIT(1), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_write_i(req_write[0]),
    .req_io_i(req_io[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .req_msk_n_i(req_msk_n[0]), .resp_valid_o(resp_valid[0]), .resp_err_o(resp_err[0]),
    .resp_rdata_o(resp_rdata[0]), .addr_o(addr[0]), .mreq_ddr_o(mreq[0]),
    .iorq_ddr_o(iorq[0]), .wr_ddr_o(wr[0]), .rd_n_o(rd_n[0]), .msk_n_o(msk_n[0]),
    .wait_n_i(wait_n[0]), .data_in_i(data_in[0]), .data_out_o(data_out[0]),
    .data_oe_o(data_oe[0])
  );

  rv4028_bus_cycle_gen #(.ADDR_W(32), .DATA_W(16), .MSK_W(2), .MIN_WAIT(1), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_write_i(req_write[1]),
    .req_io_i(req_io[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .req_msk_n_i(req_msk_n[1]), .resp_valid_o(resp_valid[1]), .resp_err_o(resp_err[1]),
    .resp_rdata_o(resp_rdata[1]), .addr_o(addr[1]), .mreq_ddr_o(mreq[1]),
    .iorq_ddr_o(iorq[1]), .wr_ddr_o(wr[1]), .rd_n_o(rd_n[1]), .msk_n_o(msk_n[1]),
    .wait_n_i(wait_n[1]), .data_in_i(data_in[1]), .data_out_o(data_out[1]),
    .data_oe_o(data_oe[1])
  );

  task automatic push_bus(input int d, input int c, input logic [1:0] m, input logic [1:0] io,
                          input logic [1:0] w, input logic rdn, input logic oe,
                          input logic [31:0] a, input logic [1:0] mk, input logic [15:0] dout);
    bus_t b;
    b.cyc = c; b.mreq = m; b.iorq = io; b.wr = w; b.rdn = rdn; b.oe = oe;
    b.addr = a; b.msk = mk; b.dout = dout;
    busq[d].push_back(b);
  endtask

  task automatic push_idle(input int d, input int c, input logic [31:0] a, input logic [1:0] mk);
    push_bus(d, c, 2'b11, 2'b11, 2'b11, 1'b1, 1'b0, a, mk, 16'h0);
  endtask

  task automatic push_rsp(input int d, input int c, input logic e, input logic [15:0] rd);
    rsp_t r;
    r.cyc = c; r.err = e; r.rdata = rd;
    rspq[d].push_back(r);
  endtask

  // Expected T1, ntw x Tw, T2 for a request handshaked in cycle c0.
  task automatic exp_cycle(input int d, input int c0, input bit io, input bit w, input int ntw,
                           input logic [31:0] a, input logic [1:0] mk, input logic [15:0] dout);
    logic [1:0] code;
    for (int k = 0; k < ntw + 2; k++) begin
      code = (k == 0) ? 2'b01 : ((k == ntw + 1) ? 2'b10 : 2'b00);
      push_bus(d, c0 + 1 + k, io ? 2'b11 : code, io ? code : 2'b11, w ? code : 2'b11,
               w, w, a, mk, dout);
    end
  endtask

  task automatic drive_req(input int d, input bit w, input bit io, input logic [31:0] a,
                           input logic [15:0] wd, input logic [1:0] mk);
    req_valid[d] = 1'b1; req_write[d] = w; req_io[d] = io;
    req_addr[d] = a; req_wdata[d] = wd; req_msk_n[d] = mk;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Monitor: compare expected bus state and responses on the falling edge.
  always @(negedge clk) begin
    bus_t b;
    rsp_t r;
    for (int d = 0; d < 2; d++) begin
      if (busq[d].size() > 0 && busq[d][0].cyc < cyc) begin
        b = busq[d].pop_front();
        tests++; fails++;
        $display("FAIL bus_missed d%0d: expectation for cyc %0d not checked (now %0d)", d, b.cyc, cyc);
      end else if (busq[d].size() > 0 && busq[d][0].cyc == cyc) begin
        b = busq[d].pop_front();
        tests++;
        if (mreq[d] !== b.mreq || iorq[d] !== b.iorq || wr[d] !== b.wr || rd_n[d] !== b.rdn ||
            data_oe[d] !== b.oe || addr[d] !== b.addr || msk_n[d] !== b.msk ||
            (b.oe && data_out[d] !== b.dout)) begin
          fails++;
          $display("FAIL bus d%0d cyc%0d: got mreq=%b iorq=%b wr=%b rd_n=%b oe=%b addr=%h msk=%b dout=%h; want mreq=%b iorq=%b wr=%b rd_n=%b oe=%b addr=%h msk=%b dout=%h",
                   d, cyc, mreq[d], iorq[d], wr[d], rd_n[d], data_oe[d], addr[d], msk_n[d], data_out[d],
                   b.mreq, b.iorq, b.wr, b.rdn, b.oe, b.addr, b.msk, b.dout);
        end
      end

      if (resp_valid[d] === 1'b1) begin
        tests++;
        if (rspq[d].size() == 0) begin
          fails++;
          $display("FAIL resp_unexpected d%0d cyc%0d: got err=%b rdata=%h, want no response",
                   d, cyc, resp_err[d], resp_rdata[d]);
        end else begin
          r = rspq[d].pop_front();
          if (r.cyc != cyc || resp_err[d] !== r.err || resp_rdata[d] !== r.rdata) begin
            fails++;
            $display("FAIL resp d%0d: got cyc=%0d err=%b rdata=%h, want cyc=%0d err=%b rdata=%h",
                     d, cyc, resp_err[d], resp_rdata[d], r.cyc, r.err, r.rdata);
          end
        end
      end else if (resp_valid[d] !== 1'b0) begin
        tests++; fails++;
        $display("FAIL resp_valid_x d%0d cyc%0d: got %b, want 0/1", d, cyc, resp_valid[d]);
      end else if (rspq[d].size() > 0 && rspq[d][0].cyc < cyc) begin
        r = rspq[d].pop_front();
        tests++; fails++;
        $display("FAIL resp_missing d%0d: got no resp_valid by cyc %0d, want one at cyc %0d", d, cyc, r.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, want finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_io[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0; req_msk_n[d] = 2'b11;
      wait_n[d] = 1'b1; data_in[d] = '0;
    end
    repeat (2) next_cycle();
    // Reset state on both instances.
    push_idle(0, cyc, 32'h0, 2'b11);
    push_idle(1, cyc, 32'h0, 2'b11);
    next_cycle();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    next_cycle();

    // Memory read, MIN_WAIT=1, no bus waits.
    c = cyc;
    drive_req(0, 1'b0, 1'b0, 32'h0000_1000, 16'h0000, 2'b00);
    data_in[0] = 16'hBEEF;
    exp_cycle(0, c, 1'b0, 1'b0, 1, 32'h0000_1000, 2'b00, 16'h0);
    push_idle(0, c + 4, 32'h0000_1000, 2'b00);
    push_rsp(0, c + 4, 1'b0, 16'hBEEF);
    next_cycle();
    req_valid[0] = 1'b0;
    repeat (5) next_cycle();

    // I/O write: iorq and wr move together, mreq stays idle.
    c = cyc;
    drive_req(0, 1'b1, 1'b1, 32'h0000_0040, 16'h1234, 2'b10);
    exp_cycle(0, c, 1'b1, 1'b1, 1, 32'h0000_0040, 2'b10, 16'h1234);
    push_idle(0, c + 4, 32'h0000_0040, 2'b10);
    push_rsp(0, c + 4, 1'b0, 16'h0000);
    next_cycle();
    req_valid[0] = 1'b0;
    repeat (5) next_cycle();

    // Read stretched by five wait_n-low cycles after the minimum wait.
    c = cyc;
    drive_req(0, 1'b0, 1'b0, 32'h0000_2002, 16'h0000, 2'b01);
    wait_n[0] = 1'b0;
    data_in[0] = 16'hA5C3;
    exp_cycle(0, c, 1'b0, 1'b0, 6, 32'h0000_2002, 2'b01, 16'h0);
    push_idle(0, c + 9, 32'h0000_2002, 2'b01);
    push_rsp(0, c + 9, 1'b0, 16'hA5C3);
    next_cycle();
    req_valid[0] = 1'b0;
    repeat (6) next_cycle();
    wait_n[0] = 1'b1;
    repeat (5) next_cycle();

    // Back-to-back reads with req_valid held through the first cycle.
    c = cyc;
    drive_req(0, 1'b0, 1'b0, 32'h0000_3000, 16'h0000, 2'b00);
    data_in[0] = 16'h1111;
    exp_cycle(0, c, 1'b0, 1'b0, 1, 32'h0000_3000, 2'b00, 16'h0);
    exp_cycle(0, c + 3, 1'b0, 1'b0, 1, 32'h0000_3004, 2'b00, 16'h0);
    push_idle(0, c + 7, 32'h0000_3004, 2'b00);
    push_rsp(0, c + 4, 1'b0, 16'h1111);
    push_rsp(0, c + 7, 1'b0, 16'h2222);
    next_cycle();
    req_addr[0] = 32'h0000_3004;
    repeat (3) next_cycle();
    req_valid[0] = 1'b0;
    data_in[0] = 16'h2222;
    repeat (5) next_cycle();

    // Reset asserted during Tw of a write: pins idle at once, no response.
    c = cyc;
    drive_req(0, 1'b1, 1'b0, 32'h0000_5000, 16'hCAFE, 2'b01);
    wait_n[0] = 1'b0;
    push_bus(0, c + 1, 2'b01, 2'b11, 2'b01, 1'b1, 1'b1, 32'h0000_5000, 2'b01, 16'hCAFE);
    push_bus(0, c + 2, 2'b00, 2'b11, 2'b00, 1'b1, 1'b1, 32'h0000_5000, 2'b01, 16'hCAFE);
    push_bus(0, c + 3, 2'b11, 2'b11, 2'b11, 1'b1, 1'b0, 32'h0000_0000, 2'b11, 16'h0);
    push_idle(0, c + 6, 32'h0000_0000, 2'b11);
    next_cycle();
    req_valid[0] = 1'b0;
    repeat (2) next_cycle();
    rst_n[0] = 1'b0;
    repeat (2) next_cycle();
    rst_n[0] = 1'b1;
    wait_n[0] = 1'b1;
    repeat (4) next_cycle();

    // Timeout instance: wait_n stuck low aborts after four counted cycles.
    c = cyc;
    drive_req(1, 1'b0, 1'b0, 32'h0000_6000, 16'h0000, 2'b00);
    wait_n[1] = 1'b0;
    data_in[1] = 16'hDEAD;
    push_bus(1, c + 1, 2'b01, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0000_6000, 2'b00, 16'h0);
    for (int k = 2; k <= 5; k++)
      push_bus(1, c + k, 2'b00, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0000_6000, 2'b00, 16'h0);
    push_idle(1, c + 6, 32'h0000_6000, 2'b00);
    push_rsp(1, c + 7, 1'b1, 16'h0000);
    next_cycle();
    req_valid[1] = 1'b0;
    repeat (6) next_cycle();
    // Following request runs normally.
    wait_n[1] = 1'b1;
    c = cyc;
    drive_req(1, 1'b0, 1'b0, 32'h0000_6100, 16'h0000, 2'b00);
    data_in[1] = 16'h0F0F;
    exp_cycle(1, c, 1'b0, 1'b0, 1, 32'h0000_6100, 2'b00, 16'h0);
    push_rsp(1, c + 4, 1'b0, 16'h0F0F);
    next_cycle();
    req_valid[1] = 1'b0;
    repeat (6) next_cycle();

    for (int d = 0; d < 2; d++) begin
      tests++;
      if (busq[d].size() != 0 || rspq[d].size() != 0) begin
        fails++;
        $display("FAIL drain d%0d: got %0d bus / %0d resp expectations left, want 0 / 0",
                 d, busq[d].size(), rspq[d].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
